// File: rtl/bk_up_pkg.sv
// Shared types and timing for the BK-0011M user-port bus-master model:
// transaction opcodes, script entries, FSM states and the default script ROM.
package bk_up_pkg;

  localparam int T_SETUP    = 2;
  localparam int T_STB      = 4;
  localparam int T_HOLD     = 1;
  localparam int T_GAP      = 8;
  localparam int SCRIPT_LEN = 7;
  localparam int IDX_W      = 3;
  localparam int ROM_DEPTH  = 1 << IDX_W;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    OP_WRW = 2'd0,
    OP_WRB = 2'd1,
    OP_RD  = 2'd2,
    OP_END = 2'd3
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_STB   = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // AY bus is inverted on the BK side, hence FFF8 selects AY register 7.
  // Unused tail slots hold END so a runaway index still terminates.
  localparam entry_t [ROM_DEPTH-1:0] SCRIPT_ROM = {
    {OP_END, 16'h0000},  // 7
    {OP_END, 16'h0000},  // 6
    {OP_RD,  16'h0000},  // 5
    {OP_WRB, 16'h0055},  // 4
    {OP_WRW, 16'hFFFE},  // 3
    {OP_RD,  16'h0000},  // 2
    {OP_WRB, 16'h00C0},  // 1
    {OP_WRW, 16'hFFF8}   // 0
  };

endpackage

// File: rtl/bk_up_script_rom.sv
// Combinational lookup of one script entry by index.
module bk_up_script_rom
  import bk_up_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output entry_t           entry_o
);

  assign entry_o = SCRIPT_ROM[idx_i];

endmodule

// File: rtl/bk_0011m.sv
// Scripted bus master for the BK-0011M user port: plays the script ROM as
// strobed word/byte writes and reads, with every output registered.
module bk_0011m
  import bk_up_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] XT5_in_pin,
  output logic [15:0] XT5_out_pin,
  output logic        nSEL2,
  output logic        STROBE,
  output logic        DOUT,
  output logic        nWRTBT,
  output logic        END,
  output logic [15:0] rd_data
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, fetch_idx;
  op_e              op_q, op_d;
  logic [15:0]      out_q, out_d;
  logic [15:0]      rd_q, rd_d;
  logic             nsel2_q, nsel2_d;
  logic             strobe_q, strobe_d;
  logic             dout_q, dout_d;
  logic             nwrtbt_q, nwrtbt_d;
  logic             end_q, end_d;
  logic             fetch;
  logic             active_d;
  entry_t           entry;

  // IDLE fetches the current (first) entry; the end of GAP fetches the next.
  assign fetch_idx = (state_q == S_IDLE) ? idx_q : idx_q + 3'd1;

  bk_up_script_rom u_rom (
    .idx_i   (fetch_idx),
    .entry_o (entry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    out_d   = out_q;
    rd_d    = rd_q;
    fetch   = 1'b0;

    unique case (state_q)
      S_IDLE: fetch = 1'b1;
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STB;
          cnt_d   = CNT_W'(T_STB - 1);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_STB: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(T_HOLD - 1);
          if (op_q == OP_RD) rd_d = XT5_in_pin;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(T_GAP - 1);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) fetch = 1'b1;
        else             cnt_d = cnt_q - 3'd1;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // Write data lands on the first SETUP clock so it is stable before STROBE.
    if (fetch) begin
      idx_d = fetch_idx;
      op_d  = entry.op;
      if (entry.op == OP_END) begin
        state_d = S_DONE;
      end else begin
        state_d = S_SETUP;
        cnt_d   = CNT_W'(T_SETUP - 1);
        if (entry.op == OP_WRW)      out_d       = entry.data;
        else if (entry.op == OP_WRB) out_d[7:0]  = entry.data[7:0];
      end
    end

    active_d = (state_d == S_SETUP) || (state_d == S_STB) || (state_d == S_HOLD);
    nsel2_d  = !active_d;
    strobe_d = (state_d == S_STB);
    dout_d   = active_d && (op_d != OP_RD);
    nwrtbt_d = !(active_d && (op_d == OP_WRB));
    end_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      op_q     <= OP_WRW;
      out_q    <= '0;
      rd_q     <= '0;
      nsel2_q  <= 1'b1;
      strobe_q <= 1'b0;
      dout_q   <= 1'b0;
      nwrtbt_q <= 1'b1;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      out_q    <= out_d;
      rd_q     <= rd_d;
      nsel2_q  <= nsel2_d;
      strobe_q <= strobe_d;
      dout_q   <= dout_d;
      nwrtbt_q <= nwrtbt_d;
      end_q    <= end_d;
    end
  end

  assign XT5_out_pin = out_q;
  assign rd_data     = rd_q;
  assign nSEL2       = nsel2_q;
  assign STROBE      = strobe_q;
  assign DOUT        = dout_q;
  assign nWRTBT      = nwrtbt_q;
  assign END         = end_q;

endmodule

// File: tb/tb_bk_0011m.sv
// Bench for bk_0011m: fixed vector table, reset corner case, and randomized
// read data checked against a cycle-indexed model of the script timeline.
module tb_bk_0011m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] XT5_in_pin = 16'h0000;
  logic [15:0] XT5_out_pin;
  logic        nSEL2, STROBE, DOUT, nWRTBT, END;
  logic [15:0] rd_data;

  bk_0011m dut (
    .clk         (clk),
    .rst         (rst),
    .XT5_in_pin  (XT5_in_pin),
    .XT5_out_pin (XT5_out_pin),
    .nSEL2       (nSEL2),
    .STROBE      (STROBE),
    .DOUT        (DOUT),
    .nWRTBT      (nWRTBT),
    .END         (END),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  localparam int TW = 0, TB = 1, TR = 2, TE = 3;
  localparam int TXN = 15;
  int          sc_op [7];
  logic [15:0] sc_dat[7];
  logic [15:0] in_val[7];

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [4:0]  ctl;   // {nSEL2, STROBE, DOUT, nWRTBT, END}
    logic [15:0] outp;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [36:0] actual();
    return {nSEL2, STROBE, DOUT, nWRTBT, END, XT5_out_pin, rd_data};
  endfunction

  // Expected outputs after n clock edges since reset release.
  function automatic logic [36:0] model(int cyc);
    logic [15:0] o, r;
    logic ns, st, d, w, e, act;
    int t, cur, ph;
    o = 16'h0; r = 16'h0; ns = 1; st = 0; d = 0; w = 1; e = 0;
    if (cyc > 0) begin
      t   = cyc - 1;
      cur = t / TXN;
      ph  = t % TXN;
      if (cur > 6) cur = 6;
      for (int j = 0; j < 6; j++) begin
        if (t >= TXN * j && j <= cur) begin
          if (sc_op[j] == TW) o = sc_dat[j];
          if (sc_op[j] == TB) o[7:0] = sc_dat[j][7:0];
        end
        if (sc_op[j] == TR && t >= TXN * j + 6) r = in_val[j];
      end
      if (sc_op[cur] == TE) e = 1;
      else begin
        act = (ph < 7);
        ns  = !act;
        st  = (ph >= 2) && (ph < 6);
        d   = act && (sc_op[cur] != TR);
        w   = !(act && (sc_op[cur] == TB));
      end
    end
    return {ns, st, d, w, e, o, r};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @n=%0d: got ctl=%b out=%h rd=%h, expected ctl=%b out=%h rd=%h",
               name, n, act[36:32], act[31:16], act[15:0], exp[36:32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic drive_pin();
    int k;
    k = n / TXN;
    XT5_in_pin = (k < 7) ? in_val[k] : 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
    drive_pin();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_state", actual(), {5'b1_0_0_1_0, 16'h0, 16'h0});
    rst = 1'b0;
    n = 0;
    drive_pin();
  endtask

  // Port protocol rules, monitored every cycle while running.
  logic prev_stb, prev_dout, prev_nw;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if ((STROBE && nSEL2) || (!nWRTBT && !DOUT) ||
          (prev_stb && STROBE && (DOUT !== prev_dout || nWRTBT !== prev_nw))) begin
        errors++;
        $display("FAIL protocol @n=%0d: STROBE=%b nSEL2=%b DOUT=%b nWRTBT=%b", n, STROBE, nSEL2, DOUT, nWRTBT);
      end
    end
    prev_stb  <= STROBE;
    prev_dout <= DOUT;
    prev_nw   <= nWRTBT;
  end

  initial begin
    sc_op[0] = TW; sc_dat[0] = 16'hFFF8;
    sc_op[1] = TB; sc_dat[1] = 16'h00C0;
    sc_op[2] = TR; sc_dat[2] = 16'h0000;
    sc_op[3] = TW; sc_dat[3] = 16'hFFFE;
    sc_op[4] = TB; sc_dat[4] = 16'h0055;
    sc_op[5] = TR; sc_dat[5] = 16'h0000;
    sc_op[6] = TE; sc_dat[6] = 16'h0000;
    for (int i = 0; i < 7; i++) in_val[i] = 16'h5432;

    tbl[0]  = '{1,   5'b0_0_1_1_0, 16'hFFF8, 16'h0000};
    tbl[1]  = '{3,   5'b0_1_1_1_0, 16'hFFF8, 16'h0000};
    tbl[2]  = '{7,   5'b0_0_1_1_0, 16'hFFF8, 16'h0000};
    tbl[3]  = '{8,   5'b1_0_0_1_0, 16'hFFF8, 16'h0000};
    tbl[4]  = '{16,  5'b0_0_1_0_0, 16'hFFC0, 16'h0000};
    tbl[5]  = '{18,  5'b0_1_1_0_0, 16'hFFC0, 16'h0000};
    tbl[6]  = '{22,  5'b0_0_1_0_0, 16'hFFC0, 16'h0000};
    tbl[7]  = '{31,  5'b0_0_0_1_0, 16'hFFC0, 16'h0000};
    tbl[8]  = '{36,  5'b0_1_0_1_0, 16'hFFC0, 16'h0000};
    tbl[9]  = '{37,  5'b0_0_0_1_0, 16'hFFC0, 16'h5432};
    tbl[10] = '{46,  5'b0_0_1_1_0, 16'hFFFE, 16'h5432};
    tbl[11] = '{61,  5'b0_0_1_0_0, 16'hFF55, 16'h5432};
    tbl[12] = '{90,  5'b1_0_0_1_0, 16'hFF55, 16'h5432};
    tbl[13] = '{91,  5'b1_0_0_1_1, 16'hFF55, 16'h5432};

    // Fixed script run with XT5_in_pin = ~ABCD.
    do_reset();
    mon_en = 1'b1;
    check("after_release", actual(), {5'b1_0_0_1_0, 16'h0, 16'h0});
    for (int i = 0; i < 14; i++) begin
      while (n < tbl[i].cyc) tick();
      check($sformatf("vec%0d", i), actual(), {tbl[i].ctl, tbl[i].outp, tbl[i].rd});
    end
    while (n < 130) tick();
    check("end_sticky", actual(), {5'b1_0_0_1_1, 16'hFF55, 16'h5432});

    // Asynchronous reset in the middle of entry 1's strobe, then replay.
    mon_en = 1'b0;
    do_reset();
    while (n < 19) tick();
    check("pre_reset_stb", actual(), {5'b0_1_1_0_0, 16'hFFC0, 16'h0000});
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", actual(), {5'b1_0_0_1_0, 16'h0, 16'h0});
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    drive_pin();
    tick();
    check("replay_entry0", actual(), {5'b0_0_1_1_0, 16'hFFF8, 16'h0000});

    // Randomized read data, full timeline compared every cycle.
    for (int run = 0; run < 5; run++) begin
      for (int i = 0; i < 7; i++) in_val[i] = 16'($urandom);
      do_reset();
      mon_en = 1'b1;
      for (int c = 0; c < 110; c++) begin
        check($sformatf("rand%0d", run), actual(), model(n));
        tick();
      end
      mon_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
